// File: rtl/timer_seq_ctrl.sv
// Profile sequencer for one general_timer: drives the timer register port through
// program / arm / wait-for-irq / clear for each table entry up to last_idx.
module timer_seq_ctrl #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [5:0]  ADDR_CTRL = 6'h00,
    parameter logic [5:0]  ADDR_LOAD = 6'h08,
    parameter logic [5:0]  ADDR_CMP  = 6'h0C,
    parameter logic [5:0]  ADDR_STAT = 6'h14,
    parameter int unsigned EN_BIT    = 0,
    parameter int unsigned LD_BIT    = 7,
    localparam int unsigned IW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    input  logic [IW-1:0] last_idx,
    input  logic          tbl_we,
    input  logic [IW-1:0] tbl_idx,
    input  logic [31:0]   tbl_load,
    input  logic [31:0]   tbl_cmp,
    input  logic [7:0]    tbl_ctrl,
    input  logic          tmr_irq,
    output logic          cs,
    output logic          we,
    output logic [5:0]    addr,
    output logic [31:0]   wdata,
    output logic          busy,
    output logic [IW-1:0] cur_idx,
    output logic          step,
    output logic          done
);

    localparam logic [2:0] EN_I = 3'(EN_BIT);
    localparam logic [2:0] LD_I = 3'(LD_BIT);

    typedef enum logic [2:0] {
        S_IDLE, S_OFF, S_LOAD, S_CMP, S_ON, S_WAIT, S_CLR, S_HALT
    } state_t;

    state_t        state;
    logic [31:0]   tbl_load_q [DEPTH];
    logic [31:0]   tbl_cmp_q  [DEPTH];
    logic [7:0]    tbl_ctrl_q [DEPTH];

    logic [IW:0]   last_ext;
    logic [IW-1:0] last_eff;
    logic          at_last;
    logic [IW-1:0] nxt_idx;

    // Out-of-range last_idx clamps to the final table entry.
    always_comb begin
        last_ext = {1'b0, last_idx};
        last_eff = (last_ext >= (IW+1)'(DEPTH)) ? IW'(DEPTH - 1) : last_idx;
        at_last  = (cur_idx == last_eff);
        nxt_idx  = at_last ? '0 : cur_idx + IW'(1);
    end

    function automatic logic [31:0] ctrl_word(input logic [7:0] c, input logic en);
        logic [7:0] v;
        v       = c;
        v[EN_I] = en;
        v[LD_I] = en;
        return {24'b0, v};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cs      <= 1'b0;
            we      <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            busy    <= 1'b0;
            cur_idx <= '0;
            step    <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                tbl_load_q[i] <= '0;
                tbl_cmp_q[i]  <= '0;
                tbl_ctrl_q[i] <= '0;
            end
        end else begin
            if (tbl_we) begin
                tbl_load_q[tbl_idx] <= tbl_load;
                tbl_cmp_q[tbl_idx]  <= tbl_cmp;
                tbl_ctrl_q[tbl_idx] <= tbl_ctrl;
            end

            cs   <= 1'b0;
            we   <= 1'b0;
            step <= 1'b0;
            done <= 1'b0;

            // Stop overrides everything once running; HALT itself always retires to IDLE.
            if (stop && state != S_IDLE && state != S_HALT) begin
                state   <= S_HALT;
                cs      <= 1'b1;
                we      <= 1'b1;
                addr    <= ADDR_CTRL;
                wdata   <= 32'h0;
                cur_idx <= '0;
                busy    <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !stop) begin
                            state   <= S_OFF;
                            cur_idx <= '0;
                            busy    <= 1'b1;
                            cs      <= 1'b1;
                            we      <= 1'b1;
                            addr    <= ADDR_CTRL;
                            wdata   <= ctrl_word(tbl_ctrl_q[0], 1'b0);
                        end
                    end
                    S_OFF: begin
                        state <= S_LOAD;
                        cs    <= 1'b1;
                        we    <= 1'b1;
                        addr  <= ADDR_LOAD;
                        wdata <= tbl_load_q[cur_idx];
                    end
                    S_LOAD: begin
                        state <= S_CMP;
                        cs    <= 1'b1;
                        we    <= 1'b1;
                        addr  <= ADDR_CMP;
                        wdata <= tbl_cmp_q[cur_idx];
                    end
                    S_CMP: begin
                        state <= S_ON;
                        cs    <= 1'b1;
                        we    <= 1'b1;
                        addr  <= ADDR_CTRL;
                        wdata <= ctrl_word(tbl_ctrl_q[cur_idx], 1'b1);
                    end
                    S_ON: begin
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (tmr_irq) begin
                            state <= S_CLR;
                            cs    <= 1'b1;
                            we    <= 1'b1;
                            addr  <= ADDR_STAT;
                            wdata <= 32'h1;
                            step  <= 1'b1;
                        end
                    end
                    S_CLR: begin
                        if (at_last && !loop_en) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state   <= S_OFF;
                            cur_idx <= nxt_idx;
                            cs      <= 1'b1;
                            we      <= 1'b1;
                            addr    <= ADDR_CTRL;
                            wdata   <= ctrl_word(tbl_ctrl_q[nxt_idx], 1'b0);
                        end
                    end
                    S_HALT: begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        cur_idx <= '0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Directed + randomized bench for timer_seq_ctrl; expected register writes come from a
// shadow profile table and the documented program/arm/clear sequence.
module tb_timer_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, loop_en, tbl_we, tmr_irq;
    logic [1:0]  last_idx, tbl_idx;
    logic [31:0] tbl_load, tbl_cmp;
    logic [7:0]  tbl_ctrl;
    logic        cs, we, busy, step, done;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  cur_idx;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] sl [4];
    logic [31:0] sc [4];
    logic [7:0]  sk [4];

    timer_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
        .last_idx(last_idx), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_load(tbl_load),
        .tbl_cmp(tbl_cmp), .tbl_ctrl(tbl_ctrl), .tmr_irq(tmr_irq), .cs(cs), .we(we),
        .addr(addr), .wdata(wdata), .busy(busy), .cur_idx(cur_idx), .step(step), .done(done)
    );

    always #5 clk = ~clk;

    task automatic do_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] bus_snap();
        return {19'b0, cs, we, addr, wdata, step, done, busy, cur_idx};
    endfunction

    function automatic logic [63:0] exp_wr(input logic [5:0] a, input logic [31:0] d,
                                           input logic st, input logic [1:0] i);
        return {19'b0, 2'b11, a, d, st, 1'b0, 1'b1, i};
    endfunction

    function automatic logic [63:0] ctl_snap();
        return {57'b0, cs, we, step, done, busy, cur_idx};
    endfunction

    task automatic tbl_wr(input int i, input logic [31:0] l, input logic [31:0] c,
                          input logic [7:0] k);
        tbl_we = 1'b1; tbl_idx = 2'(i); tbl_load = l; tbl_cmp = c; tbl_ctrl = k;
        do_cycle();
        tbl_we = 1'b0;
        sl[i] = l; sc[i] = c; sk[i] = k;
    endtask

    // Entry i's OFF write is visible on entry; returns with the ON write visible.
    task automatic prog_entry(input int i);
        logic [1:0] ii;
        ii = 2'(i);
        chk("off_wr", bus_snap(), exp_wr(6'h00, {24'b0, sk[i] & 8'h7E}, 1'b0, ii));
        do_cycle();
        chk("load_wr", bus_snap(), exp_wr(6'h08, sl[i], 1'b0, ii));
        do_cycle();
        chk("cmp_wr", bus_snap(), exp_wr(6'h0C, sc[i], 1'b0, ii));
        do_cycle();
        chk("on_wr", bus_snap(), exp_wr(6'h00, {24'b0, sk[i] | 8'h81}, 1'b0, ii));
    endtask

    // Idle WAIT cycles, then one irq cycle; returns with the CLR write visible.
    task automatic wait_clr(input int i, input int w);
        for (int k = 0; k < w; k++) begin
            do_cycle();
            chk("wait_quiet", ctl_snap(), {57'b0, 4'b0000, 1'b1, 2'(i)});
        end
        tmr_irq = 1'b1;
        do_cycle();
        tmr_irq = 1'b0;
        chk("clr_wr", bus_snap(), exp_wr(6'h14, 32'h1, 1'b1, 2'(i)));
    endtask

    task automatic run_entry(input int i, input int w);
        prog_entry(i);
        wait_clr(i, w);
    endtask

    task automatic expect_done();
        do_cycle();
        chk("done_pulse", {59'b0, cs, we, step, done, busy}, {59'b0, 5'b00010});
        do_cycle();
        chk("done_clear", {59'b0, cs, we, step, done, busy}, {59'b0, 5'b00000});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        do_cycle();
        start = 1'b0;
    endtask

    initial begin
        int last;
        rst_n = 1'b0; start = 0; stop = 0; loop_en = 0; tbl_we = 0; tmr_irq = 0;
        last_idx = 0; tbl_idx = 0; tbl_load = 0; tbl_cmp = 0; tbl_ctrl = 0;
        for (int i = 0; i < 4; i++) begin sl[i] = 0; sc[i] = 0; sk[i] = 0; end
        #22;
        chk("reset_outputs", {19'b0, cs, we, addr, wdata, step, done, busy, cur_idx}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_cycle();

        // Directed single run over two entries.
        tbl_wr(0, 32'd100, 32'd50, 8'h04);
        tbl_wr(1, 32'd200, 32'd80, 8'h04);
        last_idx = 2'd1; loop_en = 1'b0;
        pulse_start();
        run_entry(0, 3);
        do_cycle();
        run_entry(1, 1);
        expect_done();

        // Looping on a single entry: three clears, never done.
        last_idx = 2'd0; loop_en = 1'b1;
        pulse_start();
        for (int n = 0; n < 3; n++) begin
            run_entry(0, 2);
            if (n < 2) do_cycle();
        end
        stop = 1'b1;
        do_cycle();
        stop = 1'b0;
        chk("halt_wr", {23'b0, cs, we, addr, wdata, done}, {23'b0, 2'b11, 6'h00, 32'h0, 1'b0});
        do_cycle();
        chk("halt_idle", ctl_snap(), 64'h0);
        loop_en = 1'b0;

        // Stop while the LOAD write is on the bus.
        last_idx = 2'd1;
        pulse_start();
        chk("stop_off", bus_snap(), exp_wr(6'h00, {24'b0, sk[0] & 8'h7E}, 1'b0, 2'd0));
        do_cycle();
        chk("stop_load", bus_snap(), exp_wr(6'h08, sl[0], 1'b0, 2'd0));
        stop = 1'b1;
        do_cycle();
        stop = 1'b0;
        chk("stop_halt", {23'b0, cs, we, addr, wdata, done}, {23'b0, 2'b11, 6'h00, 32'h0, 1'b0});
        do_cycle();
        chk("stop_idle", ctl_snap(), 64'h0);

        // start+stop together in IDLE does nothing.
        start = 1'b1; stop = 1'b1;
        do_cycle();
        start = 1'b0; stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("startstop_idle", ctl_snap(), 64'h0);
            do_cycle();
        end

        // Table rewrite of e1 and a start pulse while e0 waits.
        last_idx = 2'd1;
        pulse_start();
        prog_entry(0);
        tbl_we = 1'b1; tbl_idx = 2'd1; tbl_load = 32'd300; tbl_cmp = sc[1]; tbl_ctrl = sk[1];
        start = 1'b1;
        do_cycle();
        tbl_we = 1'b0; start = 1'b0;
        sl[1] = 32'd300;
        chk("busy_start_ign", ctl_snap(), {57'b0, 4'b0000, 1'b1, 2'd0});
        wait_clr(0, 2);
        do_cycle();
        run_entry(1, 1);
        expect_done();

        // Randomized profiles and run lengths.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++)
                tbl_wr(i, $urandom, $urandom, 8'($urandom));
            last = int'($urandom_range(3, 0));
            last_idx = 2'(last);
            pulse_start();
            for (int i = 0; i <= last; i++) begin
                run_entry(i, int'($urandom_range(4, 1)));
                if (i < last) do_cycle();
            end
            expect_done();
        end

        // Async reset while waiting clears outputs immediately and the table.
        last_idx = 2'd0;
        pulse_start();
        prog_entry(0);
        do_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {19'b0, cs, we, addr, wdata, step, done, busy, cur_idx}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin sl[i] = 0; sc[i] = 0; sk[i] = 0; end
        do_cycle();
        chk("post_reset_idle", ctl_snap(), 64'h0);
        pulse_start();
        run_entry(0, 1);
        expect_done();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
